// File: rtl/nes_bus_sync.sv
`default_nettype none
// ============================================================================
// Module   : nes_bus_sync
// Purpose  : Synchronises the asynchronous CPU bus into SYSCLK, filters M2 and
//            frames each CPU cycle into one-clock read/write strobes.
// Revision : 1.0 - initial release
// ============================================================================
module nes_bus_sync #(
  parameter int SYNC_STAGES  = 2,
  parameter int FILT_LEN     = 2,
  parameter int STALL_CYCLES = 64
) (
  input  logic       SYSCLK,
  input  logic       nRST,
  input  logic       M2,
  input  logic       nROMSEL,
  input  logic [6:0] CPU_A,
  input  logic [7:0] CPU_D,
  input  logic       CPU_RW,
  output logic       BUS_ACTIVE,
  output logic       RD_STB,
  output logic       WR_STB,
  output logic [6:0] BUS_A,
  output logic       BUS_ROM,
  output logic [7:0] BUS_D,
  output logic       BUS_STALL
);

  localparam int SW     = 18;
  localparam int FCW    = $clog2(FILT_LEN + 1);
  localparam int SCW    = $clog2(STALL_CYCLES + 1);
  localparam int SETTLE = SYNC_STAGES + FILT_LEN;
  localparam int STW    = $clog2(SETTLE + 1);

  localparam logic [FCW-1:0] c_FILT_LAST  = FCW'(FILT_LEN - 1);
  localparam logic [SCW-1:0] c_STALL_LAST = SCW'(STALL_CYCLES - 1);
  localparam logic [SCW-1:0] c_STALL_MAX  = SCW'(STALL_CYCLES);
  localparam logic [STW-1:0] c_SETTLE     = STW'(SETTLE);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_HIGH  = 2'd2,
    ST_STALL = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0][SW-1:0] r_sync;
  logic [SW-1:0]  w_pins;
  logic [SW-1:0]  w_sync;
  logic           w_m2_s;
  logic           w_romsel_n_s;
  logic           w_rw_s;
  logic [6:0]     w_a_s;
  logic [7:0]     w_d_s;

  logic [FCW-1:0] r_filt_cnt;
  logic           r_m2f;
  logic           r_m2f_d;
  logic           w_rise;
  logic           w_fall;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [SCW-1:0] r_stall_cnt;
  logic [STW-1:0] r_settle_cnt;
  logic           r_rw;
  logic           r_rd_stb;
  logic           r_wr_stb;
  logic [6:0]     r_bus_a;
  logic           r_bus_rom;
  logic [7:0]     r_bus_d;
  logic           r_bus_stall;

  logic           w_enter;
  logic           w_rd_nxt;
  logic           w_wr_nxt;
  logic           w_stall_set;
  logic           w_d_cap;

  assign w_pins       = {M2, nROMSEL, CPU_RW, CPU_A, CPU_D};
  assign w_sync       = r_sync[SYNC_STAGES-1];
  assign w_m2_s       = w_sync[17];
  assign w_romsel_n_s = w_sync[16];
  assign w_rw_s       = w_sync[15];
  assign w_a_s        = w_sync[14:8];
  assign w_d_s        = w_sync[7:0];

  always_ff @(posedge SYSCLK or negedge nRST) begin
    if (!nRST) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_pins};
    end
  end

  // M2f only follows the synced pin after FILT_LEN consecutive disagreeing samples
  always_ff @(posedge SYSCLK or negedge nRST) begin
    if (!nRST) begin
      r_filt_cnt <= '0;
      r_m2f      <= 1'b0;
      r_m2f_d    <= 1'b0;
    end else begin
      r_m2f_d <= r_m2f;
      if (w_m2_s != r_m2f) begin
        if (r_filt_cnt == c_FILT_LAST) begin
          r_m2f      <= ~r_m2f;
          r_filt_cnt <= '0;
        end else begin
          r_filt_cnt <= r_filt_cnt + 1'b1;
        end
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  assign w_rise = r_m2f & ~r_m2f_d;
  assign w_fall = ~r_m2f & r_m2f_d;

  always_ff @(posedge SYSCLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    w_rd_nxt    = 1'b0;
    w_wr_nxt    = 1'b0;
    w_stall_set = 1'b0;
    w_d_cap     = 1'b0;
    case (r_state)
      // Hold off until the sync/filter pipe has filled, so a cycle already
      // in flight at reset release is seen high and discarded.
      ST_INIT: begin
        if ((r_settle_cnt == c_SETTLE) && !r_m2f && !w_m2_s) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_HIGH;
          w_enter     = 1'b1;
          w_rd_nxt    = w_rw_s;
        end
      end
      ST_HIGH: begin
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
          w_wr_nxt    = ~r_rw;
        end else begin
          w_d_cap = 1'b1;
          if (r_stall_cnt == c_STALL_LAST) begin
            w_state_nxt = ST_STALL;
            w_stall_set = 1'b1;
          end
        end
      end
      ST_STALL: begin
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge SYSCLK or negedge nRST) begin
    if (!nRST) begin
      r_settle_cnt <= '0;
      r_stall_cnt  <= '0;
      r_rw         <= 1'b0;
      r_rd_stb     <= 1'b0;
      r_wr_stb     <= 1'b0;
      r_bus_a      <= '0;
      r_bus_rom    <= 1'b0;
      r_bus_d      <= '0;
      r_bus_stall  <= 1'b0;
    end else begin
      r_rd_stb <= w_rd_nxt;
      r_wr_stb <= w_wr_nxt;
      if ((r_state == ST_INIT) && (r_settle_cnt != c_SETTLE)) begin
        r_settle_cnt <= r_settle_cnt + 1'b1;
      end
      if (w_enter) begin
        r_bus_a     <= w_a_s;
        r_bus_rom   <= ~w_romsel_n_s;
        r_rw        <= w_rw_s;
        r_stall_cnt <= '0;
        r_bus_stall <= 1'b0;
      end else if (((r_state == ST_HIGH) || (r_state == ST_STALL)) &&
                   (r_stall_cnt != c_STALL_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_d_cap) begin
        r_bus_d <= w_d_s;
      end
      if (w_stall_set) begin
        r_bus_stall <= 1'b1;
      end
    end
  end

  assign BUS_ACTIVE = (r_state == ST_HIGH);
  assign RD_STB     = r_rd_stb;
  assign WR_STB     = r_wr_stb;
  assign BUS_A      = r_bus_a;
  assign BUS_ROM    = r_bus_rom;
  assign BUS_D      = r_bus_d;
  assign BUS_STALL  = r_bus_stall;

endmodule
`default_nettype wire

// File: tb/tb_nes_bus_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_nes_bus_sync
// Purpose  : Directed self-checking bench for nes_bus_sync.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nes_bus_sync;

  logic       clk;
  logic       nrst;
  logic       m2;
  logic       nromsel;
  logic [6:0] cpu_a;
  logic [7:0] cpu_d;
  logic       cpu_rw;
  logic       bus_active;
  logic       rd_stb;
  logic       wr_stb;
  logic [6:0] bus_a;
  logic       bus_rom;
  logic [7:0] bus_d;
  logic       bus_stall;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt  = 0;
  int wr_cnt  = 0;
  int both_cnt = 0;
  int rd0;
  int wr0;

  nes_bus_sync #(
    .SYNC_STAGES (2),
    .FILT_LEN    (2),
    .STALL_CYCLES(64)
  ) dut (
    .SYSCLK    (clk),
    .nRST      (nrst),
    .M2        (m2),
    .nROMSEL   (nromsel),
    .CPU_A     (cpu_a),
    .CPU_D     (cpu_d),
    .CPU_RW    (cpu_rw),
    .BUS_ACTIVE(bus_active),
    .RD_STB    (rd_stb),
    .WR_STB    (wr_stb),
    .BUS_A     (bus_a),
    .BUS_ROM   (bus_rom),
    .BUS_D     (bus_d),
    .BUS_STALL (bus_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rd_stb) rd_cnt++;
    if (wr_stb) wr_cnt++;
    if (rd_stb && wr_stb) both_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    rd0 = rd_cnt;
    wr0 = wr_cnt;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_active"}, {31'd0, bus_active}, 32'd0);
    chk({tag, "_rd"},     {31'd0, rd_stb},     32'd0);
    chk({tag, "_wr"},     {31'd0, wr_stb},     32'd0);
    chk({tag, "_a"},      {25'd0, bus_a},      32'd0);
    chk({tag, "_rom"},    {31'd0, bus_rom},    32'd0);
    chk({tag, "_d"},      {24'd0, bus_d},      32'd0);
    chk({tag, "_stall"},  {31'd0, bus_stall},  32'd0);
  endtask

  initial begin
    nrst = 1'b0; m2 = 1'b0; nromsel = 1'b1; cpu_a = 7'h00; cpu_d = 8'h00; cpu_rw = 1'b1;
    step(3);
    chk_outputs_zero("reset");
    nrst = 1'b1;
    step(10);

    // Write cycle
    mark();
    cpu_a = 7'h41; cpu_d = 8'hA5; cpu_rw = 1'b0; m2 = 1'b1;
    step(8);
    chk("wr_active_mid", {31'd0, bus_active}, 32'd1);
    step(8);
    m2 = 1'b0;
    step(10);
    cpu_d = 8'h00;
    chk("wr_count",  wr_cnt - wr0, 32'd1);
    chk("wr_no_rd",  rd_cnt - rd0, 32'd0);
    chk("wr_bus_a",  {25'd0, bus_a}, 32'h41);
    chk("wr_bus_d",  {24'd0, bus_d}, 32'hA5);
    chk("wr_rom",    {31'd0, bus_rom}, 32'd0);
    chk("wr_idle",   {31'd0, bus_active}, 32'd0);

    // Read cycle: strobe exactly five clocks after the pin rises
    mark();
    cpu_a = 7'h48; nromsel = 1'b1; cpu_rw = 1'b1; m2 = 1'b1;
    step(4);
    chk("rd_early", {31'd0, rd_stb}, 32'd0);
    step(1);
    chk("rd_stb_5clk", {31'd0, rd_stb}, 32'd1);
    chk("rd_bus_a",    {25'd0, bus_a}, 32'h48);
    chk("rd_rom",      {31'd0, bus_rom}, 32'd0);
    step(1);
    chk("rd_pulse_end", {31'd0, rd_stb}, 32'd0);
    step(10);
    m2 = 1'b0;
    step(10);
    chk("rd_count", rd_cnt - rd0, 32'd1);
    chk("rd_no_wr", wr_cnt - wr0, 32'd0);

    // ROM-space write
    mark();
    cpu_a = 7'h00; cpu_d = 8'h3C; nromsel = 1'b0; cpu_rw = 1'b0; m2 = 1'b1;
    step(12);
    m2 = 1'b0;
    step(10);
    nromsel = 1'b1;
    chk("rom_wr_count", wr_cnt - wr0, 32'd1);
    chk("rom_flag",     {31'd0, bus_rom}, 32'd1);
    chk("rom_bus_a",    {25'd0, bus_a}, 32'h00);
    chk("rom_bus_d",    {24'd0, bus_d}, 32'h3C);

    // Glitches shorter than the filter length: isolated high pulse, then a dip
    mark();
    cpu_a = 7'h12; cpu_d = 8'h5A; cpu_rw = 1'b0; m2 = 1'b1;
    step(1);
    m2 = 1'b0;
    step(10);
    chk("glitch_pulse_rd", rd_cnt - rd0, 32'd0);
    chk("glitch_pulse_wr", wr_cnt - wr0, 32'd0);
    chk("glitch_pulse_a",  {25'd0, bus_a}, 32'h00);
    m2 = 1'b1;
    step(6);
    m2 = 1'b0;
    step(1);
    m2 = 1'b1;
    step(8);
    m2 = 1'b0;
    step(10);
    chk("glitch_dip_wr", wr_cnt - wr0, 32'd1);
    chk("glitch_dip_rd", rd_cnt - rd0, 32'd0);
    chk("glitch_bus_a",  {25'd0, bus_a}, 32'h12);
    chk("glitch_bus_d",  {24'd0, bus_d}, 32'h5A);

    // Stall: HIGH entered 5 clk after the pin, threshold 64 clk later
    mark();
    cpu_a = 7'h22; cpu_d = 8'h11; cpu_rw = 1'b0; m2 = 1'b1;
    step(68);
    chk("stall_pre_active", {31'd0, bus_active}, 32'd1);
    chk("stall_pre_flag",   {31'd0, bus_stall},  32'd0);
    step(1);
    chk("stall_active", {31'd0, bus_active}, 32'd0);
    chk("stall_flag",   {31'd0, bus_stall},  32'd1);
    step(31);
    m2 = 1'b0;
    step(10);
    chk("stall_flag_hold", {31'd0, bus_stall}, 32'd1);
    chk("stall_no_wr",     wr_cnt - wr0, 32'd0);
    chk("stall_no_rd",     rd_cnt - rd0, 32'd0);
    cpu_a = 7'h33; cpu_rw = 1'b1; m2 = 1'b1;
    step(6);
    chk("stall_cleared", {31'd0, bus_stall},  32'd0);
    chk("stall_next_act",{31'd0, bus_active}, 32'd1);
    chk("stall_next_rd", rd_cnt - rd0, 32'd1);
    m2 = 1'b0;
    step(10);

    // Reset release with M2 already high: that cycle is discarded
    nrst = 1'b0; m2 = 1'b1; cpu_rw = 1'b0; cpu_a = 7'h55; cpu_d = 8'h77;
    step(3);
    nrst = 1'b1;
    mark();
    step(20);
    chk("inflight_no_rd", rd_cnt - rd0, 32'd0);
    chk("inflight_no_wr", wr_cnt - wr0, 32'd0);
    chk("inflight_bus_a", {25'd0, bus_a}, 32'h00);
    chk("inflight_active",{31'd0, bus_active}, 32'd0);
    m2 = 1'b0;
    step(10);
    chk("inflight_fall_wr", wr_cnt - wr0, 32'd0);
    m2 = 1'b1;
    step(16);
    m2 = 1'b0;
    step(10);
    chk("inflight_next_wr", wr_cnt - wr0, 32'd1);
    chk("inflight_next_a",  {25'd0, bus_a}, 32'h55);
    chk("inflight_next_d",  {24'd0, bus_d}, 32'h77);

    // Reset asserted mid-cycle
    mark();
    cpu_a = 7'h66; cpu_d = 8'h99; cpu_rw = 1'b0; m2 = 1'b1;
    step(9);
    chk("midrst_pre_active", {31'd0, bus_active}, 32'd1);
    nrst = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    step(3);
    nrst = 1'b1;
    step(10);
    m2 = 1'b0;
    step(10);
    chk("midrst_no_wr", wr_cnt - wr0, 32'd0);
    chk("midrst_bus_a", {25'd0, bus_a}, 32'h00);

    chk("strobes_exclusive", both_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
